// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//                Holds the fetch FSM state encoding, the default filler
//                instruction and a small alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    // Fetch FSM. DRAIN waits for the response of a killed request and drops it.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_DATA = 2'd2,
        DRAIN     = 2'd3
    } fetch_state_e;

    // addi x0,x0,0 - placed in the buffer for trapped (misaligned) fetches
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_if
//  Description : Bus bundle around the fetch stage: PC register handshake,
//                flush, instruction-memory request/response and the
//                valid/ready link to decode.
//  Modports    : master - the fetch stage itself
//                slave  - the environment (PC register, imem, decode)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    // PC register side
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    // instruction memory side
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    // decode side
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              if_exc;
    logic              if_ready;

    modport master (
        input  pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_inst, if_exc
    );

    modport slave (
        output pc, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_inst, if_exc
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_fifo
//  Description : DEPTH-entry buffer of fetched {pc, inst, exc} words.
//                Push and pop in the same cycle are accepted even when full.
//                clear_i empties the buffer and wins over push/pop.
//  Ports       : clk, rst_n (sync, active-low), clear_i, push_i, data_i,
//                pop_i, data_o (zero when empty), full_o, empty_o, count_o
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push_ok, w_pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign w_pop_ok  = pop_i & ~empty_o;
    // a simultaneous pop frees the slot the push needs
    assign w_push_ok = push_i & (~full_o | w_pop_ok);
    assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // power-of-two depth: pointers wrap naturally
            if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: data_o is masked while empty
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Fetch stage behind the PC register. Issues one imem request
//                at a time, buffers returned words tagged with their PC and
//                hands them to decode over valid/ready. Flush kills buffered
//                entries and any in-flight response.
//  Ports       : clk, rst_n (sync, active-low), bus (inst_fetch_if.master:
//                pc/pc_valid/pc_ready, flush, imem_*, if_*)
//  Macro       : INST_FETCH_MISALIGN_EN - when defined, a misaligned PC is not
//                fetched; a NOP entry with if_exc=1 is buffered instead. When
//                undefined, pc[1:0] is forced to 00 and if_exc is always 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);
    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam int                ENT_W     = ADDR_W + 32 + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
`ifdef INST_FETCH_MISALIGN_EN
    localparam bit                MISALIGN_EN = 1'b1;
`else
    localparam bit                MISALIGN_EN = 1'b0;
`endif

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // flush seen while waiting for grant: the granted response must be dropped
    logic              kill_q, kill_d;

    logic              w_outstanding, w_misaligned, w_issue;
    logic              w_push, w_pop, w_full, w_empty, w_head_exc;
    logic [CNT_W-1:0]  w_count, w_reserved;
    logic [ENT_W-1:0]  w_push_data, w_head;

    // a slot is reserved for the in-flight response so it can never overflow
    assign w_outstanding = (state_q != IDLE);
    assign w_reserved    = w_count + CNT_W'(w_outstanding);
    assign w_misaligned  = MISALIGN_EN && is_misaligned(bus.pc[1:0]);
    assign w_issue       = rst_n && (state_q == IDLE) && bus.pc_valid && !bus.flush
                           && !w_full && (w_reserved < CNT_W'(DEPTH));
    assign w_pop         = bus.if_valid && bus.if_ready && !bus.flush;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        kill_d      = kill_q;
        w_push      = 1'b0;
        w_push_data = {addr_q & WORD_MASK, bus.imem_rdata, 1'b0};
        case (state_q)
            IDLE: begin
                if (w_issue) begin
                    if (w_misaligned) begin
                        // trap entry goes straight into the buffer, no memory access
                        w_push      = 1'b1;
                        w_push_data = {bus.pc, NOP_INST, 1'b1};
                    end else begin
                        addr_d  = bus.pc;
                        kill_d  = 1'b0;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                // request stays up even after a flush; memory may already own it
                if (bus.imem_gnt) begin
                    state_d = (bus.flush || kill_q) ? DRAIN : WAIT_DATA;
                    kill_d  = 1'b0;
                end else if (bus.flush) begin
                    kill_d  = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (bus.imem_rvalid) begin
                    w_push  = !bus.flush;
                    state_d = IDLE;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (bus.flush),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign bus.pc_ready  = w_issue;
    assign bus.imem_req  = (state_q == WAIT_GNT);
    assign bus.imem_addr = addr_q & WORD_MASK;
    assign bus.if_valid  = !w_empty;
    assign bus.if_pc     = w_head[ENT_W-1 -: ADDR_W];
    assign bus.if_inst   = w_head[32:1];
    assign w_head_exc    = w_head[0];
    assign bus.if_exc    = w_head_exc & MISALIGN_EN;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch. Stimulus pushes expected
//                decode entries into a queue; a monitor pops and compares on
//                every if_valid & if_ready handshake. A memory responder
//                answers requests with configurable grant/data delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) bus ();

    inst_fetch #(
        .DEPTH    (2),
        .ADDR_W   (32),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          gnt_dly     = 0;
    int          rv_dly      = 0;
    bit          ov_en       = 1'b0;
    logic [31:0] ov_data     = 32'h0;
    int          req_cnt     = 0;
    int          rdy_cnt     = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst, input logic exc);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.exc  = exc;
        exp_q.push_back(e);
    endtask

    // called on a negedge; returns on the negedge after pc was captured
    task automatic issue_pc(input logic [31:0] addr);
        bit got = 1'b0;
        bus.pc       = addr;
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (bus.pc_ready === 1'b1) got = 1'b1;
            @(negedge clk);
        end
        bus.pc_valid = 1'b0;
        chk("issue_handshake", 65'(got), 65'(1));
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            #4;
            i++;
        end
        chk("drain_left", 65'(exp_q.size()), 65'(0));
        @(negedge clk);
    endtask

    // memory responder: gnt after gnt_dly cycles of req, data rv_dly cycles after gnt
    initial begin
        logic [31:0] a;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.imem_req === 1'b1) begin
                a = bus.imem_addr;
                for (int k = 0; k < gnt_dly; k++) begin
                    @(negedge clk);
                    chk("req_held", 65'(bus.imem_req), 65'(1));
                    chk("addr_held", 65'(bus.imem_addr), 65'(a));
                end
                bus.imem_gnt = 1'b1;
                @(negedge clk);
                bus.imem_gnt = 1'b0;
                for (int k = 0; k < rv_dly; k++) @(negedge clk);
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ov_en ? ov_data : {16'hC0DE, a[15:0]};
                @(negedge clk);
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'h0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n === 1'b1) begin
                if (bus.imem_req === 1'b1) req_cnt++;
                if (bus.pc_valid === 1'b1 && bus.pc_ready === 1'b1) rdy_cnt++;
                if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
                    a.pc   = bus.if_pc;
                    a.inst = bus.if_inst;
                    a.exc  = bus.if_exc;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_entry: got pc %0h inst %0h, required none", a.pc, a.inst);
                    end else begin
                        e = exp_q.pop_front();
                        chk("entry", a, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int n, bad, r0;
        rst_n        = 1'b0;
        bus.pc       = 32'h0;
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.if_ready = 1'b0;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        bus.pc_valid = 1'b1;
        #1;
        chk("rst_pc_ready",  65'(bus.pc_ready),  65'(0));
        chk("rst_imem_req",  65'(bus.imem_req),  65'(0));
        chk("rst_if_valid",  65'(bus.if_valid),  65'(0));
        chk("rst_if_exc",    65'(bus.if_exc),    65'(0));
        chk("rst_imem_addr", 65'(bus.imem_addr), 65'(0));
        chk("rst_if_pc",     65'(bus.if_pc),     65'(0));
        chk("rst_if_inst",   65'(bus.if_inst),   65'(0));
        @(negedge clk);
        bus.pc_valid = 1'b0;
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;
        @(negedge clk);

        // ---------------- 1: in-order fetch of 0, 4, 8
        r0 = rdy_cnt;
        expect_entry(32'h0, 32'hC0DE_0000, 1'b0);
        issue_pc(32'h0);
        n = 1;
        #3;
        while (bus.if_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("t1_latency", 65'(n), 65'(3));
        @(negedge clk);
        expect_entry(32'h4, 32'hC0DE_0004, 1'b0);
        issue_pc(32'h4);
        expect_entry(32'h8, 32'hC0DE_0008, 1'b0);
        issue_pc(32'h8);
        wait_drain(40);
        chk("t1_pc_ready_pulses", 65'(rdy_cnt - r0), 65'(3));

        // ---------------- 2: decode stalled, buffer fills to 2
        bus.if_ready = 1'b0;
        expect_entry(32'h10, 32'hC0DE_0010, 1'b0);
        issue_pc(32'h10);
        expect_entry(32'h14, 32'hC0DE_0014, 1'b0);
        issue_pc(32'h14);
        bus.pc       = 32'h18;
        bus.pc_valid = 1'b1;
        repeat (3) @(negedge clk);
        bad = 0;
        repeat (6) begin
            #1;
            if (bus.pc_ready !== 1'b0 || bus.imem_req !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t2_backpressure", 65'(bad), 65'(0));
        #1;
        chk("t2_head_valid", 65'(bus.if_valid), 65'(1));
        chk("t2_head_pc",    65'(bus.if_pc),    65'(32'h10));
        bus.pc_valid = 1'b0;
        bus.if_ready = 1'b1;
        wait_drain(20);

        // ---------------- 3: flush in WAIT_DATA, buffered entry and response dropped
        bus.if_ready = 1'b0;
        issue_pc(32'h30);
        repeat (3) @(negedge clk);
        #1;
        chk("t3_buffered", 65'(bus.if_valid), 65'(1));
        @(negedge clk);
        rv_dly  = 1;
        ov_en   = 1'b1;
        ov_data = 32'hDEAD_BEEF;
        issue_pc(32'h20);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        #1;
        chk("t3_dropped_valid", 65'(bus.if_valid), 65'(0));
        @(negedge clk);
        #1;
        chk("t3_still_empty", 65'(bus.if_valid), 65'(0));
        chk("t3_no_req",      65'(bus.imem_req), 65'(0));
        rv_dly       = 0;
        ov_en        = 1'b0;
        bus.if_ready = 1'b1;
        @(negedge clk);
        bus.pc       = 32'h50;
        bus.pc_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("t3_flush_blocks_issue", 65'(bus.pc_ready), 65'(0));
        @(negedge clk);
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b0;
        expect_entry(32'h40, 32'hC0DE_0040, 1'b0);
        issue_pc(32'h40);
        wait_drain(30);

        // ---------------- 4: flush in WAIT_GNT, grant 3 cycles late
        gnt_dly = 3;
        issue_pc(32'h60);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_no_entry", 65'(bus.if_valid), 65'(0));
        chk("t4_idle",     65'(bus.imem_req), 65'(0));
        gnt_dly = 0;
        @(negedge clk);
        expect_entry(32'h64, 32'hC0DE_0064, 1'b0);
        issue_pc(32'h64);
        wait_drain(30);

        // ---------------- 5: pop and push in the same cycle
        bus.if_ready = 1'b0;
        expect_entry(32'h70, 32'hC0DE_0070, 1'b0);
        issue_pc(32'h70);
        repeat (2) @(negedge clk);
        rv_dly = 2;
        expect_entry(32'h74, 32'hC0DE_0074, 1'b0);
        issue_pc(32'h74);
        repeat (3) @(negedge clk);
        bus.if_ready = 1'b1;
        #1;
        chk("t5_coincide", 65'({bus.imem_rvalid, bus.if_valid}), 65'(2'b11));
        wait_drain(20);
        rv_dly = 0;

        // ---------------- 6: misaligned PC
`ifdef INST_FETCH_MISALIGN_EN
        r0 = req_cnt;
        expect_entry(32'h6, 32'h0000_0013, 1'b1);
        issue_pc(32'h6);
        #1;
        chk("t6_trap_valid", 65'(bus.if_valid), 65'(1));
        wait_drain(10);
        chk("t6_no_req", 65'(req_cnt - r0), 65'(0));
`else
        expect_entry(32'h4, 32'hC0DE_0004, 1'b0);
        issue_pc(32'h6);
        #1;
        chk("t6_aligned_addr", 65'(bus.imem_addr), 65'(32'h4));
        wait_drain(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
